gl_fetch_prefetch: RTL and testbench

Next-generation instruction fetch for the GL command pipeline. Replaces the single-word fetch with a parametrised prefetch engine:
- Issues pipelined reads to the instruction BRAM, which has a fixed READ_LATENCY.
- Buffers returned words in a DEPTH-entry FIFO.
- Presents instructions to gl_decode over a valid/ready handshake.
- Supports redirect (jump or operand skip) and halt.

---
 rtl/gl_pkg.sv | 20 ++
 rtl/gl_sync_fifo.sv | 69 ++++++
 rtl/gl_fetch_prefetch.sv | 159 +++++++++++++++
 tb/tb_gl_fetch_prefetch.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gl_pkg.sv
// Shared GL pipeline definitions: instruction field layout, opcodes and fetch state encoding.
package gl_pkg;

  localparam int unsigned TYPE_BIT = 31;
  localparam int unsigned IMM_MSB  = 30;
  localparam int unsigned IMM_LSB  = 8;
  localparam int unsigned OP_MSB   = 7;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_JUMP = 8'h10;
  localparam logic [7:0] OP_SKIP = 8'h11;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalted
  } state_e;

endpackage

// File: rtl/gl_sync_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count; DEPTH must be a power of two.
module gl_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    push_ok  = push && ((count_q != CntW'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/gl_fetch_prefetch.sv
// Prefetching instruction fetch for the GL pipeline with redirect and halt.
// Optional GL_FETCH_PERF_EN adds saturating stall and flush counters.
module gl_fetch_prefetch
  import gl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [7:0]  HALT_OPCODE  = OP_HALT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic              busy
`ifdef GL_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [15:0]       perf_flushes
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned EntW = ADDR_W + DATA_W;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [ADDR_W-1:0]       pipe_addr_q [READ_LATENCY];
  logic [ADDR_W-1:0]       pipe_addr_d [READ_LATENCY];

  logic [CntW-1:0] fifo_count;
  logic            fifo_empty, fifo_full, fifo_push, fifo_pop, fifo_flush;
  logic [EntW-1:0] fifo_rdata;
  int unsigned     inflight;
  logic            redirect_act, halt_push;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < int'(READ_LATENCY); i++) inflight = inflight + 32'(pipe_vld_q[i]);

    redirect_act = redirect_en && (state_q != StIdle);
    // Words returning after a halt, or into a flushed pipe, are dropped here.
    fifo_push    = pipe_vld_q[READ_LATENCY-1] && (state_q == StRun) && !redirect_act;
    halt_push    = fifo_push && (mem_data[OP_MSB:0] == HALT_OPCODE);
    fifo_flush   = redirect_act;
    fifo_pop     = inst_valid && inst_ready && !redirect_act;

    mem_en = (state_q == StRun) && !redirect_act && !halt_push && !fifo_full &&
             ((32'(fifo_count) + inflight) < DEPTH);

    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          pc_d    = start_addr;
        end
      end
      StRun: begin
        if (redirect_act) pc_d = redirect_addr;
        else if (halt_push) state_d = StHalted;
      end
      StHalted: begin
        if (redirect_act) begin
          state_d = StRun;
          pc_d    = redirect_addr;
        end
      end
      default: state_d = StIdle;
    endcase
    if (mem_en) pc_d = pc_q + ADDR_W'(1);

    pipe_vld_d[0]  = mem_en;
    pipe_addr_d[0] = pc_q;
    for (int i = 1; i < int'(READ_LATENCY); i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
    if (redirect_act) pipe_vld_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) pipe_addr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < int'(READ_LATENCY); i++) pipe_addr_q[i] <= pipe_addr_d[i];
    end
  end

  gl_sync_fifo #(
    .WIDTH (EntW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata ({pipe_addr_q[READ_LATENCY-1], mem_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign mem_addr   = pc_q;
  assign inst_valid = !fifo_empty;
  assign inst_data  = inst_valid ? fifo_rdata[DATA_W-1:0] : '0;
  assign inst_addr  = inst_valid ? fifo_rdata[EntW-1:DATA_W] : '0;
  assign halted     = (state_q == StHalted);
  assign busy       = (state_q != StIdle) || !fifo_empty;

`ifdef GL_FETCH_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (inst_valid && !inst_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (redirect_act && (!fifo_empty || (inflight != 0)) && (flush_q != '1)) begin
      flush_d = flush_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_flushes      = flush_q;
`endif

endmodule

// File: tb/tb_gl_fetch_prefetch.sv
// Self-checking bench for gl_fetch_prefetch: directed scenarios plus a randomized stream model.
module tb_gl_fetch_prefetch;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 4;
  localparam int unsigned RL  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, inst_ready, redirect_en;
  logic [AW-1:0] start_addr, redirect_addr, mem_addr, inst_addr;
  logic          mem_en, inst_valid, halted, busy;
  logic [DW-1:0] mem_data, inst_data;

  logic          b_start, b_mem_en, b_inst_valid, b_halted, b_busy;
  logic [3:0]    b_start_addr, b_mem_addr, b_inst_addr;
  logic [DW-1:0] b_mem_data, b_inst_data;
  logic          b_inst_ready   = 1'b1;
  logic          b_redirect_en  = 1'b0;
  logic [3:0]    b_redirect_addr = 4'h0;

`ifdef GL_FETCH_PERF_EN
  logic [31:0] perf_stall_cycles, b_perf_stall_cycles;
  logic [15:0] perf_flushes, b_perf_flushes;
`endif

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] halt_addr = 16'hFFF0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == halt_addr) return 32'h0000_00FF;
    return DW'(a);
  endfunction

  // BRAM models: fixed read latency, mem[i] = i.
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_word(mem_addr);
    for (int i = 1; i < int'(RL); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_data = rd_pipe[RL-1];

  always @(posedge clk) b_mem_data <= DW'(b_mem_addr);

  gl_fetch_prefetch #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .READ_LATENCY(RL), .HALT_OPCODE(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_addr(inst_addr), .redirect_en(redirect_en), .redirect_addr(redirect_addr),
    .halted(halted), .busy(busy)
`ifdef GL_FETCH_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
`endif
  );

  gl_fetch_prefetch #(
    .ADDR_W(4), .DATA_W(DW), .DEPTH(4), .READ_LATENCY(1), .HALT_OPCODE(8'hFF)
  ) dut_w (
    .clk(clk), .reset(reset), .start(b_start), .start_addr(b_start_addr),
    .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
    .inst_valid(b_inst_valid), .inst_ready(b_inst_ready), .inst_data(b_inst_data),
    .inst_addr(b_inst_addr), .redirect_en(b_redirect_en), .redirect_addr(b_redirect_addr),
    .halted(b_halted), .busy(b_busy)
`ifdef GL_FETCH_PERF_EN
    , .perf_stall_cycles(b_perf_stall_cycles), .perf_flushes(b_perf_flushes)
`endif
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; redirect_en = 1'b0; inst_ready = 1'b0;
    start_addr = '0; redirect_addr = '0; b_start = 1'b0; b_start_addr = '0;
    halt_addr = 16'hFFF0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({mem_en, mem_addr, inst_valid, inst_data, inst_addr, halted, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {mem_en, mem_addr, inst_valid, inst_data, inst_addr, halted, busy});
    end
    checks++;
    if ({b_mem_en, b_inst_valid, b_busy, b_halted} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs_w: got %b expected 0000",
               {b_mem_en, b_inst_valid, b_busy, b_halted});
    end
    next_cycle();
  endtask

  task automatic test_latency_stream();
    int first_valid = -1;
    int pops = 0;
    logic [AW-1:0] exp = 16'h10;
    do_reset();
    for (int cyc = 0; cyc < 16; cyc++) begin
      start      = (cyc == 0) || (cyc == 8);  // second start must be ignored
      start_addr = (cyc == 0) ? 16'h10 : 16'h99;
      inst_ready = 1'b1;
      #1;
      if (inst_valid && first_valid < 0) first_valid = cyc;
      if (inst_valid) begin
        checks++;
        if (inst_addr !== exp || inst_data !== DW'(exp)) begin
          errors++;
          $display("FAIL stream_order: got addr %h data %h expected %h", inst_addr, inst_data, exp);
        end
        exp++;
        pops++;
      end
      next_cycle();
    end
    checks++;
    if (first_valid != 4) begin
      errors++;
      $display("FAIL first_valid_cycle: got %0d expected 4", first_valid);
    end
    checks++;
    if (pops != 12) begin
      errors++;
      $display("FAIL throughput: got %0d pops expected 12", pops);
    end
  endtask

  task automatic test_backpressure();
    int issued = 0;
    int popped = 0;
    logic [AW-1:0] exp_pop = 16'h10;
    logic [AW-1:0] exp_iss = 16'h10;
    do_reset();
    for (int cyc = 0; cyc < 72; cyc++) begin
      start      = (cyc == 0);
      start_addr = 16'h10;
      inst_ready = (cyc < 12) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      if (cyc == 11) begin
        checks++;
        if (issued != 4 || mem_en !== 1'b0 || inst_valid !== 1'b1) begin
          errors++;
          $display("FAIL backpressure_fill: got issued %0d mem_en %b valid %b expected 4 0 1",
                   issued, mem_en, inst_valid);
        end
      end
      if (mem_en) begin
        checks++;
        if (mem_addr !== exp_iss || (issued - popped) >= int'(DEP)) begin
          errors++;
          $display("FAIL backpressure_issue: got addr %h outstanding %0d expected %h below %0d",
                   mem_addr, issued - popped, exp_iss, DEP);
        end
        issued++;
        exp_iss++;
      end
      if (inst_valid) begin
        checks++;
        if (inst_addr !== exp_pop || inst_data !== DW'(exp_pop)) begin
          errors++;
          $display("FAIL backpressure_head: got %h/%h expected %h", inst_addr, inst_data, exp_pop);
        end
        if (inst_ready) begin
          exp_pop++;
          popped++;
        end
      end
      next_cycle();
    end
    checks++;
    if (popped < 15) begin
      errors++;
      $display("FAIL backpressure_progress: got %0d pops expected at least 15", popped);
    end
  endtask

  task automatic test_redirect();
    int pops = 0;
    logic [AW-1:0] exp = 16'h40;
    do_reset();
    redirect_en = 1'b1;
    redirect_addr = 16'h77;
    #1;
    next_cycle();
    redirect_en = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL redirect_idle: got busy %b mem_en %b expected 0 0", busy, mem_en);
    end
    next_cycle();
    for (int cyc = 0; cyc <= 30; cyc++) begin
      start         = (cyc == 0);
      start_addr    = 16'h10;
      redirect_en   = (cyc == 5);
      redirect_addr = 16'h40;
      inst_ready    = (cyc >= 5);
      #1;
      if (cyc == 5) begin
        checks++;
        if (mem_en !== 1'b0 || inst_valid !== 1'b1) begin
          errors++;
          $display("FAIL redirect_cycle: got mem_en %b valid %b expected 0 1", mem_en, inst_valid);
        end
      end else if (cyc > 5 && inst_valid) begin
        checks++;
        if (inst_addr !== exp || inst_data !== DW'(exp)) begin
          errors++;
          $display("FAIL redirect_stream: got %h/%h expected %h", inst_addr, inst_data, exp);
        end
        exp++;
        pops++;
      end
      next_cycle();
    end
    redirect_en = 1'b0;
    checks++;
    if (pops != 22) begin
      errors++;
      $display("FAIL redirect_pops: got %0d expected 22", pops);
    end
  endtask

  task automatic test_halt();
    int pops_before = 0;
    int pops_after = 0;
    bit halt_done = 0;
    logic [AW-1:0] exp = 16'h10;
    do_reset();
    halt_addr = 16'h13;
    for (int cyc = 0; cyc <= 26; cyc++) begin
      start         = (cyc == 0);
      start_addr    = 16'h10;
      inst_ready    = 1'b1;
      redirect_en   = (cyc == 20);
      redirect_addr = 16'h20;
      if (cyc == 20) exp = 16'h20;
      #1;
      if (cyc < 20 && halt_done) begin
        checks++;
        if (inst_valid !== 1'b0 || mem_en !== 1'b0 || halted !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL halt_hold: got valid %b mem_en %b halted %b busy %b expected 0 0 1 1",
                   inst_valid, mem_en, halted, busy);
        end
      end else if (cyc != 20 && inst_valid) begin
        checks++;
        if (inst_addr !== exp || inst_data !== mem_word(exp) ||
            halted !== (cyc < 20 && exp == 16'h13)) begin
          errors++;
          $display("FAIL halt_stream: got %h/%h halted %b expected %h/%h", inst_addr, inst_data,
                   halted, exp, mem_word(exp));
        end
        if (cyc < 20) begin
          pops_before++;
          halt_done = (exp == 16'h13);
        end else begin
          pops_after++;
        end
        exp++;
      end
      if (cyc == 21) begin
        checks++;
        if (halted !== 1'b0) begin
          errors++;
          $display("FAIL halt_release: got halted %b expected 0", halted);
        end
      end
      next_cycle();
    end
    redirect_en = 1'b0;
    checks++;
    if (pops_before != 4 || pops_after != 3) begin
      errors++;
      $display("FAIL halt_counts: got %0d/%0d expected 4/3", pops_before, pops_after);
    end
  endtask

  task automatic test_reset_mid();
    int first_valid = -1;
    logic [AW-1:0] exp = 16'h30;
    do_reset();
    for (int cyc = 0; cyc < 6; cyc++) begin
      start = (cyc == 0);
      start_addr = 16'h10;
      inst_ready = 1'b0;
      next_cycle();
    end
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_addr, inst_valid, inst_data, inst_addr, halted, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected 0",
               {mem_en, mem_addr, inst_valid, inst_data, inst_addr, halted, busy});
    end
    next_cycle();
    for (int cyc = 0; cyc < 10; cyc++) begin
      start = (cyc == 0);
      start_addr = 16'h30;
      inst_ready = 1'b1;
      #1;
      if (inst_valid) begin
        if (first_valid < 0) first_valid = cyc;
        checks++;
        if (inst_addr !== exp || inst_data !== DW'(exp)) begin
          errors++;
          $display("FAIL reset_mid_stream: got %h/%h expected %h", inst_addr, inst_data, exp);
        end
        exp++;
      end
      next_cycle();
    end
    checks++;
    if (first_valid != 4) begin
      errors++;
      $display("FAIL reset_mid_latency: got %0d expected 4", first_valid);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] got [$];
    logic [3:0] exp = 4'hF;
    do_reset();
    for (int cyc = 0; cyc < 10; cyc++) begin
      b_start = (cyc == 0);
      b_start_addr = 4'hF;
      #1;
      if (b_inst_valid) begin
        got.push_back(b_inst_addr);
        checks++;
        if (b_inst_addr !== exp || b_inst_data !== DW'(exp)) begin
          errors++;
          $display("FAIL wrap_stream: got %h/%h expected %h", b_inst_addr, b_inst_data, exp);
        end
        exp++;
      end
      next_cycle();
    end
    b_start = 1'b0;
    checks++;
    if (got.size() < 3) begin
      errors++;
      $display("FAIL wrap_count: got %0d words expected at least 3", got.size());
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] exp_pop, exp_iss;
    logic [DW-1:0] exp_w;
    int outstanding = 0;
    int pops = 0;
    bit done = 0;
    do_reset();
    halt_addr = 16'h47;
    exp_pop = AW'($urandom_range(32'h20, 32'h5F));
    exp_iss = exp_pop;
    for (int cyc = 0; cyc < 400; cyc++) begin
      start         = (cyc == 0);
      start_addr    = exp_pop;
      inst_ready    = ($urandom_range(0, 3) != 0);
      redirect_en   = (cyc > 2) && ($urandom_range(0, 24) == 0);
      redirect_addr = AW'($urandom_range(0, 32'h7F));
      #1;
      if (mem_en) begin
        checks++;
        if (mem_addr !== exp_iss || outstanding >= int'(DEP) || done || cyc == 0 || redirect_en) begin
          errors++;
          $display("FAIL rand_issue: got %h outstanding %0d done %b expected %h", mem_addr,
                   outstanding, done, exp_iss);
        end
        exp_iss++;
        outstanding++;
      end
      if (inst_valid) begin
        exp_w = mem_word(exp_pop);
        checks++;
        if (inst_addr !== exp_pop || inst_data !== exp_w || done) begin
          errors++;
          $display("FAIL rand_head: got %h/%h done %b expected %h/%h", inst_addr, inst_data,
                   done, exp_pop, exp_w);
        end
        if (inst_ready && !redirect_en) begin
          done = (exp_w[7:0] == 8'hFF);
          exp_pop++;
          outstanding--;
          pops++;
        end
      end
      if (done && !redirect_en) begin
        checks++;
        if (halted !== 1'b1) begin
          errors++;
          $display("FAIL rand_halted: got %b expected 1", halted);
        end
      end
      if (redirect_en) begin
        exp_pop = redirect_addr;
        exp_iss = redirect_addr;
        outstanding = 0;
        done = 0;
      end
      next_cycle();
    end
    redirect_en = 1'b0;
    checks++;
    if (pops < 50) begin
      errors++;
      $display("FAIL rand_progress: got %0d pops expected at least 50", pops);
    end
  endtask

  initial begin
    test_reset();
    test_latency_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
